lives_hud_ctrl: RTL and testbench



---
 rtl/lives_hud_pkg.sv | 16 +
 rtl/lives_blink_fsm.sv | 60 ++++++
 rtl/lives_hud_ctrl.sv | 117 +++++++++++
 tb/tb_lives_hud_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lives_hud_pkg.sv
// Shared types and geometry helpers for the lives HUD controller.
package lives_hud_pkg;

    typedef enum logic {IDLE, BLINK} blink_state_t;

    function automatic int sprite_side(input int address);
        return 1 << (address / 2);
    endfunction

    localparam int SPRITE_SIDE = sprite_side(8);

    function automatic int slot_left(input int k, input int origin_x, input int spacing);
        return origin_x + k * spacing;
    endfunction

endpackage

// File: rtl/lives_blink_fsm.sv
// Blink sequencer for the icon of a just-lost life; steps once per frame.
module lives_blink_fsm
    import lives_hud_pkg::*;
#(
    parameter int MAX_LIVES    = 5,
    parameter int BLINK_FRAMES = 60,
    parameter int BLINK_HALF   = 8,
    localparam int LC_BITS     = $clog2(MAX_LIVES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               life_lost,
    input  logic [LC_BITS-1:0] lives_count,
    output logic               blinking,
    output logic [LC_BITS-1:0] blink_slot,
    output logic               show
);

    localparam int FL_BITS = $clog2(BLINK_FRAMES + 1);
    localparam int HC_BITS = $clog2(BLINK_HALF + 1);

    blink_state_t        state;
    logic [FL_BITS-1:0]  frames_left;
    logic [HC_BITS-1:0]  half_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            blink_slot  <= '0;
            frames_left <= '0;
            half_cnt    <= '0;
            show        <= 1'b0;
        end else if (life_lost && lives_count < LC_BITS'(MAX_LIVES)) begin
            // A new loss always restarts, even on a frame_start cycle.
            state       <= BLINK;
            blink_slot  <= lives_count;
            frames_left <= FL_BITS'(BLINK_FRAMES);
            half_cnt    <= '0;
            show        <= 1'b0;
        end else if (state == BLINK && frame_start) begin
            if (frames_left == FL_BITS'(1)) begin
                state <= IDLE;
                show  <= 1'b0;
            end else begin
                frames_left <= frames_left - 1'b1;
                if (half_cnt == HC_BITS'(BLINK_HALF - 1)) begin
                    half_cnt <= '0;
                    show     <= ~show;
                end else begin
                    half_cnt <= half_cnt + 1'b1;
                end
            end
        end
    end

    assign blinking = (state == BLINK);

endmodule

// File: rtl/lives_hud_ctrl.sv
// Lives HUD: frame-latched life count, slot decode and 2-stage sprite pipeline.
module lives_hud_ctrl
    import lives_hud_pkg::*;
#(
    parameter int ADDRESS       = 8,
    parameter int COLOR_BITS    = 24,
    parameter int X_BITS        = 10,
    parameter int Y_BITS        = 10,
    parameter int ORIGIN_X      = 8,
    parameter int ORIGIN_Y      = 8,
    parameter int SPACING       = 20,
    parameter int MAX_LIVES     = 5,
    parameter int BLINK_FRAMES  = 60,
    parameter int BLINK_HALF    = 8,
    parameter logic [COLOR_BITS-1:0] TRANSPARENT = '0,
    localparam int LC_BITS      = $clog2(MAX_LIVES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    input  logic [X_BITS-1:0]     pix_x,
    input  logic [Y_BITS-1:0]     pix_y,
    input  logic [LC_BITS-1:0]    lives_count,
    input  logic                  life_lost,
    output logic [ADDRESS-1:0]    rom_addr,
    input  logic [COLOR_BITS-1:0] rom_data,
    output logic [COLOR_BITS-1:0] rgb_out,
    output logic                  hit_out,
    output logic                  out_valid,
    output logic                  blinking
);

    localparam int SW   = sprite_side(ADDRESS);
    localparam int HALF = ADDRESS / 2;

    logic [LC_BITS-1:0] lives_frame;
    logic [LC_BITS-1:0] blink_slot;
    logic               show;

    lives_blink_fsm #(
        .MAX_LIVES    (MAX_LIVES),
        .BLINK_FRAMES (BLINK_FRAMES),
        .BLINK_HALF   (BLINK_HALF)
    ) u_blink (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .life_lost   (life_lost),
        .lives_count (lives_count),
        .blinking    (blinking),
        .blink_slot  (blink_slot),
        .show        (show)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lives_frame <= '0;
        else if (frame_start)
            lives_frame <= (lives_count > LC_BITS'(MAX_LIVES)) ? LC_BITS'(MAX_LIVES) : lives_count;
    end

    // Signed offsets: a negative difference means the pixel is left of / above the slot.
    logic signed [Y_BITS:0] dy;
    logic                   y_in;
    assign dy   = $signed({1'b0, pix_y}) - $signed((Y_BITS + 1)'(ORIGIN_Y));
    assign y_in = !dy[Y_BITS] && (dy[Y_BITS-1:0] < Y_BITS'(SW));

    logic signed [X_BITS:0] dx [MAX_LIVES];
    logic [MAX_LIVES-1:0]   slot_in;
    logic [MAX_LIVES-1:0]   slot_vis;

    for (genvar k = 0; k < MAX_LIVES; k++) begin : g_slot
        assign dx[k]       = $signed({1'b0, pix_x})
                           - $signed((X_BITS + 1)'(slot_left(k, ORIGIN_X, SPACING)));
        assign slot_in[k]  = !dx[k][X_BITS] && (dx[k][X_BITS-1:0] < X_BITS'(SW));
        assign slot_vis[k] = (LC_BITS'(k) < lives_frame)
                           || (blinking && blink_slot == LC_BITS'(k) && show);
    end

    logic               s1_hit_nxt;
    logic [ADDRESS-1:0] s1_addr_nxt;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        s1_hit_nxt  = 1'b0;
        s1_addr_nxt = '0;
        for (int k = 0; k < MAX_LIVES; k++) begin
            if (pix_valid && y_in && slot_in[k] && slot_vis[k]) begin
                s1_hit_nxt  = 1'b1;
                s1_addr_nxt = {dy[HALF-1:0], dx[k][HALF-1:0]};
            end
        end
    end

    logic s1_hit;
    logic s1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr  <= '0;
            s1_hit    <= 1'b0;
            s1_valid  <= 1'b0;
            rgb_out   <= '0;
            hit_out   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            rom_addr  <= s1_addr_nxt;
            s1_hit    <= s1_hit_nxt;
            s1_valid  <= pix_valid;
            rgb_out   <= s1_hit ? rom_data : '0;
            hit_out   <= s1_hit && (rom_data != TRANSPARENT);
            out_valid <= s1_valid;
        end
    end

endmodule

// File: tb/tb_lives_hud_ctrl.sv
// Scoreboard bench for lives_hud_ctrl with a behavioural async sprite ROM.
module tb_lives_hud_ctrl;
    import lives_hud_pkg::*;

    localparam int ORIGIN_X = 8;
    localparam int ORIGIN_Y = 8;
    localparam int SPACING  = 20;
    localparam int MAX      = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic [2:0]  lives_count = '0;
    logic        life_lost = 1'b0;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic [23:0] rgb_out;
    logic        hit_out;
    logic        out_valid;
    logic        blinking;

    lives_hud_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .lives_count (lives_count),
        .life_lost   (life_lost),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rgb_out     (rgb_out),
        .hit_out     (hit_out),
        .out_valid   (out_valid),
        .blinking    (blinking)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_f(input logic [7:0] a);
        return (a == 8'h00) ? 24'h000000 : {a, ~a, 8'h3C};
    endfunction

    assign rom_data = rom_f(rom_addr);

    typedef struct packed {
        logic [23:0] rgb;
        logic        hit;
        logic        valid;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_addr_prev = '0;
    bit         addr_pending = 0;
    int         exp_lives = 0;
    int         exp_slot = 0;
    bit         exp_blink = 0;
    bit         exp_show = 0;
    int         n_vec = 0;
    int         n_err = 0;

    function automatic void model(input int x, input int y, input bit v,
                                  output bit h, output logic [7:0] a);
        int  lx;
        bit  vis;
        h = 0;
        a = '0;
        for (int k = 0; k < MAX; k++) begin
            lx  = ORIGIN_X + k * SPACING;
            vis = (k < exp_lives) || (exp_blink && k == exp_slot && exp_show);
            if (v && vis && x >= lx && x < lx + SPRITE_SIDE
                  && y >= ORIGIN_Y && y < ORIGIN_Y + SPRITE_SIDE) begin
                h = 1;
                a = 8'(((y - ORIGIN_Y) << 4) | (x - lx));
            end
        end
    endfunction

    // One pixel clock: compare matured expectations, then drive new inputs and queue results.
    task automatic step(input int x, input int y, input bit v, input bit fs, input bit ll);
        exp_t       e;
        bit         h;
        logic [7:0] a;
        @(negedge clk);
        if (addr_pending) begin
            n_vec++;
            if (rom_addr !== exp_addr_prev) begin
                n_err++;
                $display("FAIL rom_addr got %h want %h", rom_addr, exp_addr_prev);
            end
        end
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            n_vec++;
            if ({rgb_out, hit_out, out_valid} !== {e.rgb, e.hit, e.valid}) begin
                n_err++;
                $display("FAIL pixel rgb/hit/valid got %h/%b/%b want %h/%b/%b",
                         rgb_out, hit_out, out_valid, e.rgb, e.hit, e.valid);
            end
        end
        pix_x       = 10'(x);
        pix_y       = 10'(y);
        pix_valid   = v;
        frame_start = fs;
        life_lost   = ll;
        model(x, y, v, h, a);
        e.rgb   = h ? rom_f(a) : 24'h0;
        e.hit   = h && (rom_f(a) != 24'h0);
        e.valid = v;
        sb.push_back(e);
        exp_addr_prev = a;
        addr_pending  = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic new_frame(input bit ll);
        step(0, 0, 0, 1, ll);
        exp_lives = (lives_count > MAX) ? MAX : int'(lives_count);
    endtask

    task automatic chk_blink(input bit want);
        @(posedge clk);
        #1;
        n_vec++;
        if (blinking !== want) begin
            n_err++;
            $display("FAIL blinking got %b want %b", blinking, want);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        n_vec++;
        if ({rom_addr, rgb_out, hit_out, out_valid, blinking} !== '0) begin
            n_err++;
            $display("FAIL %s addr/rgb/hit/valid/blink got %h/%h/%b/%b/%b want all 0",
                     tag, rom_addr, rgb_out, hit_out, out_valid, blinking);
        end
    endtask

    // Frame k counts frame_starts after the blink load; slot visibility follows the half-period.
    task automatic blink_frames(input int from_k, input int to_k, input int slot_x, input int slot_y);
        for (int k = from_k; k <= to_k; k++) begin
            new_frame(0);
            exp_blink = (k <= 59);
            exp_show  = exp_blink && (((k / 8) % 2) == 1);
            chk_blink(exp_blink);
            step(slot_x, slot_y, 1, 0, 0);
            step(53, 12, 1, 0, 0);
            step(30, 10, 1, 0, 0);
            idle(1);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_row_scan;
        lives_count = 3'd3;
        new_frame(0);
        for (int x = 0; x <= 120; x++) step(x, 8, 1, 0, 0);
        step(30, 10, 1, 0, 0);
        step(10, 7, 1, 0, 0);
        step(10, 23, 1, 0, 0);
        step(10, 24, 1, 0, 0);
        step(30, 10, 0, 0, 0);
        idle(3);
    endtask

    task automatic test_midframe_latch;
        lives_count = 3'd3;
        new_frame(0);
        step(53, 12, 1, 0, 0);
        lives_count = 3'd1;
        step(53, 12, 1, 0, 0);
        step(30, 10, 1, 0, 0);
        new_frame(0);
        step(53, 12, 1, 0, 0);
        step(30, 10, 1, 0, 0);
        step(10, 10, 1, 0, 0);
        idle(3);
    endtask

    task automatic test_blink;
        lives_count = 3'd2;
        new_frame(0);
        step(0, 0, 0, 0, 1);
        exp_blink = 1;
        exp_slot  = 2;
        exp_show  = 0;
        chk_blink(1'b1);
        step(53, 12, 1, 0, 0);
        blink_frames(1, 61, 53, 12);
        idle(3);
    endtask

    task automatic test_reload;
        lives_count = 3'd2;
        new_frame(1);
        exp_blink = 1;
        exp_slot  = 2;
        exp_show  = 0;
        chk_blink(1'b1);
        blink_frames(1, 19, 53, 12);
        lives_count = 3'd1;
        step(0, 0, 0, 0, 1);
        exp_slot = 1;
        exp_show = 0;
        chk_blink(1'b1);
        blink_frames(1, 60, 30, 10);
        idle(3);
    endtask

    task automatic test_saturate_and_reset;
        lives_count = 3'd7;
        new_frame(0);
        for (int x = 80; x <= 112; x += 2) step(x, 10, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        chk_blink(1'b0);
        step(90, 10, 1, 0, 0);
        step(91, 11, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        addr_pending = 0;
        exp_lives = 0;
        exp_blink = 0;
        exp_show  = 0;
        step(30, 10, 1, 0, 0);
        step(90, 10, 1, 0, 0);
        step(10, 10, 1, 0, 0);
        idle(2);
        new_frame(0);
        step(90, 10, 1, 0, 0);
        step(30, 10, 1, 0, 0);
        idle(3);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_row_scan();
        test_midframe_latch();
        test_blink();
        test_reload();
        test_saturate_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
